// File: rtl/axil_instr_mem_slave.sv
// axil_instr_mem_slave
//   AXI-Lite read-only slave in front of a synchronous instruction ROM.
//   Each accepted AR request is turned into a one-cycle ROM read (or an
//   SLVERR marker when the word address is past MEM_DEPTH). The read result
//   lands in a small response FIFO that drives the R channel in acceptance
//   order.
//
//   Ports
//     clk, rst        : clock, synchronous active-high reset
//     ARADDR/ARVALID/ARREADY : read address channel (word address)
//     RDATA/RRESP/RVALID/RREADY : read data channel
//     mem_en, mem_addr : synchronous ROM read request
//     mem_rdata        : ROM data, valid the cycle after mem_en
module axil_instr_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 3,
  localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 2);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
  } rsp_t;

  rsp_t            fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [OW-1:0]   occ;
  logic            inflight, inflight_err;

  logic [CW-1:0]   credits;
  logic            ar_hs, in_range, push, pop;
  rsp_t            push_rsp, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  // Credits cover the in-flight ROM read too, so the push one cycle after
  // an accept always has a free FIFO slot.
  assign credits  = CW'(occ) + CW'(inflight);
  assign ARREADY  = !rst && (credits < CW'(FIFO_DEPTH));
  assign ar_hs    = ARVALID && ARREADY;
  assign in_range = {1'b0, ARADDR} < DEPTH_EXT;

  assign mem_en   = ar_hs && in_range;
  assign mem_addr = mem_en ? ARADDR[MEM_AW-1:0] : '0;

  // Out-of-range requests ride the same in-flight slot so they stay in order.
  assign push     = inflight;
  assign push_rsp = inflight_err ? rsp_t'{data: '0, resp: 2'b10}
                                 : rsp_t'{data: mem_rdata, resp: 2'b00};

  assign head   = fifo_q[rd_ptr];
  assign RVALID = !rst && (occ != '0);
  assign pop    = RVALID && RREADY;
  assign RDATA  = RVALID ? head.data : '0;
  assign RRESP  = RVALID ? head.resp : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      inflight     <= ar_hs;
      inflight_err <= ar_hs && !in_range;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates everything that reads it.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= push_rsp;
  end

endmodule

// File: doc/axil_instr_mem_slave.md
AXIL_INSTR_MEM_SLAVE -- requirements
Module: axil_instr_mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the ARADDR width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the RDATA and mem_rdata width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 1024, meaning the number of instruction words; MEM_AW = clog2(MEM_DEPTH).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 3, meaning the response buffer entries; minimum 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port ARADDR, input, ADDR_WIDTH bits: word address (byte PC >> 2).
REQ-008 The block SHALL have port ARVALID, input, 1 bit: read address valid.
REQ-009 The block SHALL have port ARREADY, output, 1 bit: read address accept.
REQ-010 The block SHALL have port RDATA, output, DATA_WIDTH bits: read data (instruction word).
REQ-011 The block SHALL have port RRESP, output, 2 bits: 2'b00 OKAY, 2'b10 SLVERR.
REQ-012 The block SHALL have port RVALID, output, 1 bit: read data valid.
REQ-013 The block SHALL have port RREADY, input, 1 bit: read data accept.
REQ-014 The block SHALL have port mem_en, output, 1 bit: synchronous ROM read enable.
REQ-015 The block SHALL have port mem_addr, output, MEM_AW bits: ROM word index.
REQ-016 The block SHALL have port mem_rdata, input, DATA_WIDTH bits: ROM data, valid the cycle after mem_en.

Function
REQ-017 An AR handshake SHALL occur in any cycle where ARVALID && ARREADY.
REQ-018 The credit count SHALL equal FIFO occupancy plus in-flight ROM reads (0 or 1).
REQ-019 ARREADY SHALL equal (count < FIFO_DEPTH) and SHALL have no combinational dependence on ARVALID or RREADY.
REQ-020 For an in-range handshake (ARADDR < MEM_DEPTH) in cycle N, the block SHALL drive mem_en=1 and mem_addr=ARADDR[MEM_AW-1:0] in cycle N.
REQ-021 In cycle N+1, the block SHALL push {mem_rdata, 2'b00} into the FIFO at the end of that cycle.
REQ-022 For an out-of-range handshake (ARADDR >= MEM_DEPTH), mem_en SHALL stay 0, and {0, 2'b10} SHALL be pushed at the end of cycle N+1 through the same in-flight slot, preserving order.
REQ-023 mem_en SHALL be 0 in every cycle without an in-range handshake; mem_addr is don't-care when mem_en=0.
REQ-024 RVALID SHALL equal FIFO non-empty; RDATA and RRESP SHALL show the FIFO head, giving minimum latency handshake N -> RVALID N+2.
REQ-025 A pop SHALL occur on RVALID && RREADY; a push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-026 While RVALID=1 and RREADY=0, RDATA and RRESP SHALL hold stable and RVALID SHALL stay 1.
REQ-027 Responses SHALL return in strict acceptance order; the FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 The credit rule SHALL guarantee that a push never finds the FIFO full; there SHALL be no overflow path and no drop.
REQ-029 With RREADY held at 1 and ARVALID held at 1, the block SHALL sustain one accept and one response per cycle in steady state (occupancy 1 plus in-flight 1).
REQ-030 With RREADY held at 0, the block SHALL accept exactly FIFO_DEPTH requests, then hold ARREADY=0 until a pop.

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL clear the FIFO pointers, occupancy and in-flight flag.
REQ-032 During reset, outputs SHALL be ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, mem_en=0, mem_addr=0.
REQ-033 ARREADY SHALL rise in the first cycle after rst deasserts.
REQ-034 Reset mid-operation SHALL discard in-flight and buffered responses; no response from before reset SHALL appear after reset.

Verification
REQ-035 The bench SHALL cover single read: ROM[5]=0x00500093, ARADDR=5 accepted in cycle N -> mem_en=1 and mem_addr=5 in N, RVALID=1 with RDATA=0x00500093 and RRESP=00 in N+2.
REQ-036 The bench SHALL cover streaming: ARADDR=0..7 back-to-back, RREADY=1 -> eight responses in order on consecutive cycles, ARREADY never low after the first.
REQ-037 The bench SHALL cover backpressure: RREADY=0 with ARVALID=1 -> exactly 3 accepts, then ARREADY=0; RREADY=1 -> data for words 0,1,2 in order, then ARREADY=1 again.
REQ-038 The bench SHALL cover out of range: ARADDR=1024 between ARADDR=1 and ARADDR=2 -> mem_en=0 for it, and responses are word1/OKAY, 0/SLVERR, word2/OKAY in that order.
REQ-039 The bench SHALL cover reset mid-stream: rst=1 while 2 responses are buffered and 1 is in flight -> RVALID=0 next cycle; after release, a new read of ARADDR=3 returns only ROM[3].
REQ-040 The bench SHALL cover stability: RVALID=1 with RREADY toggled randomly -> RDATA and RRESP never change while RVALID=1 and RREADY=0.
